// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row at a time, debounces press and release,
// and emits a single keypad_enable pulse with the key code per accepted press.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_en,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] keypad_data,
    output logic       keypad_enable,
    output logic       key_held
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CntW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CNT);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

    state_e          state_q, state_d;
    logic [3:0]      col_s1_q, col_s2_q;
    logic [DivW-1:0] div_q;
    logic [1:0]      row_idx_q, row_idx_d;
    logic [1:0]      col_idx_q, col_idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      data_q, data_d;
    logic            en_q, en_d;

    logic            tick;
    logic            any_low;
    logic [1:0]      low_col;
    logic            col_high;
    logic [CntW-1:0] cnt_inc;

    assign tick     = (div_q == DivLast);
    assign any_low  = ~&col_s2_q;
    assign col_high = col_s2_q[col_idx_q];
    assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

    // Lowest-index low column wins when several are pressed on one row.
    always_comb begin
        low_col = 2'd0;
        if (!col_s2_q[0])      low_col = 2'd0;
        else if (!col_s2_q[1]) low_col = 2'd1;
        else if (!col_s2_q[2]) low_col = 2'd2;
        else if (!col_s2_q[3]) low_col = 2'd3;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_s1_q  <= 4'b1111;
            col_s2_q  <= 4'b1111;
            div_q     <= '0;
            state_q   <= StScan;
            row_idx_q <= 2'd0;
            col_idx_q <= 2'd0;
            cnt_q     <= '0;
            data_q    <= 4'd0;
            en_q      <= 1'b0;
        end else begin
            col_s1_q  <= col_in;
            col_s2_q  <= col_s1_q;
            div_q     <= tick ? '0 : div_q + DivW'(1);
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            col_idx_q <= col_idx_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            en_q      <= en_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        col_idx_d = col_idx_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        en_d      = 1'b0;
        if (!scan_en) begin
            state_d = StScan;
            cnt_d   = '0;
        end else if (tick) begin
            unique case (state_q)
                StScan: begin
                    if (any_low) begin
                        col_idx_d = low_col;
                        cnt_d     = CntOne;
                        state_d   = StDebounce;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                StDebounce: begin
                    if (!col_high) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CntMax) begin
                            data_d  = {row_idx_q, col_idx_q};
                            en_d    = 1'b1;
                            cnt_d   = '0;
                            state_d = StPressed;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = StScan;
                    end
                end
                StPressed: begin
                    if (col_high) begin
                        cnt_d   = CntOne;
                        state_d = StRelease;
                    end
                end
                StRelease: begin
                    if (col_high) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CntMax) begin
                            cnt_d     = '0;
                            row_idx_d = row_idx_q + 2'd1;
                            state_d   = StScan;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = StPressed;
                    end
                end
                default: state_d = StScan;
            endcase
        end
    end

    assign row_out       = ~(4'b0001 << row_idx_q);
    assign keypad_data   = data_q;
    assign keypad_enable = en_q;
    assign key_held      = (state_q == StPressed) || (state_q == StRelease);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3) driving a modelled key matrix.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scan_en = 1'b1;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  keypad_data;
    logic        keypad_enable;
    logic        key_held;
    logic [15:0] keys = 16'h0000;

    int total = 0;
    int bad = 0;
    int en_cnt = 0;
    int base = 0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_CNT(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .scan_en(scan_en),
        .col_in(col_in),
        .row_out(row_out),
        .keypad_data(keypad_data),
        .keypad_enable(keypad_enable),
        .key_held(key_held)
    );

    // Key at (r,c) pulls column c low while row r is driven low.
    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end

    always @(posedge clk) if (keypad_enable === 1'b1) en_cnt <= en_cnt + 1;

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the negedge just before the first post-reset edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clks(2);
        reset = 1'b0;
    endtask

    initial begin
        // Idle scan after reset
        keys = 16'h0000;
        do_reset();
        base = en_cnt;
        chk("rst_row", 32'(row_out), 32'hE);
        chk("rst_data", 32'(keypad_data), 32'h0);
        chk("rst_en", 32'(keypad_enable), 32'h0);
        chk("rst_held", 32'(key_held), 32'h0);
        clks(3);  chk("idle_row0", 32'(row_out), 32'hE);
        clks(1);  chk("idle_row1", 32'(row_out), 32'hD);
        clks(4);  chk("idle_row2", 32'(row_out), 32'hB);
        clks(4);  chk("idle_row3", 32'(row_out), 32'h7);
        clks(4);  chk("idle_wrap", 32'(row_out), 32'hE);
        chk("idle_nopulse", 32'(en_cnt - base), 32'h0);

        // Hold row 1 col 2
        do_reset();
        keys = 16'h0040;
        base = en_cnt;
        clks(15);
        chk("k6_pre_en", 32'(keypad_enable), 32'h0);
        chk("k6_pre_data", 32'(keypad_data), 32'h0);
        clks(1);
        chk("k6_en", 32'(keypad_enable), 32'h1);
        chk("k6_data", 32'(keypad_data), 32'h6);
        chk("k6_held", 32'(key_held), 32'h1);
        clks(1);  chk("k6_en_one_clk", 32'(keypad_enable), 32'h0);
        clks(23);
        chk("k6_count", 32'(en_cnt - base), 32'h1);
        chk("k6_held_long", 32'(key_held), 32'h1);
        chk("k6_row_kept", 32'(row_out), 32'hD);
        keys = 16'h0000;
        clks(11); chk("k6_rel_held", 32'(key_held), 32'h1);
        clks(1);
        chk("k6_rel_done", 32'(key_held), 32'h0);
        chk("k6_rel_row", 32'(row_out), 32'hB);
        chk("k6_rel_count", 32'(en_cnt - base), 32'h1);

        // Bounce on row 0 col 0: low 2 ticks, high 1 tick
        do_reset();
        base = en_cnt;
        repeat (3) begin
            keys = 16'h0001;
            clks(8);
            chk("bounce_row", 32'(row_out), 32'hE);
            keys = 16'h0000;
            clks(4);
        end
        chk("bounce_nopulse", 32'(en_cnt - base), 32'h0);
        chk("bounce_data", 32'(keypad_data), 32'h0);
        chk("bounce_held", 32'(key_held), 32'h0);

        // Row 2 cols 1 and 3 together, then release glitch
        do_reset();
        keys = 16'h0A00;
        base = en_cnt;
        clks(19); chk("k9_pre_en", 32'(keypad_enable), 32'h0);
        clks(1);
        chk("k9_en", 32'(keypad_enable), 32'h1);
        chk("k9_data", 32'(keypad_data), 32'h9);
        clks(20);
        chk("k9_count", 32'(en_cnt - base), 32'h1);
        chk("k9_held", 32'(key_held), 32'h1);
        chk("k9_row", 32'(row_out), 32'hB);
        keys = 16'h0000;
        clks(4);  chk("glitch_rel_held", 32'(key_held), 32'h1);
        keys = 16'h0A00;
        clks(4);
        chk("glitch_held", 32'(key_held), 32'h1);
        chk("glitch_count", 32'(en_cnt - base), 32'h1);
        keys = 16'h0000;
        clks(11); chk("glitch_final_held", 32'(key_held), 32'h1);
        clks(1);
        chk("glitch_final_drop", 32'(key_held), 32'h0);
        chk("glitch_final_count", 32'(en_cnt - base), 32'h1);
        chk("glitch_data_kept", 32'(keypad_data), 32'h9);
        chk("glitch_row_adv", 32'(row_out), 32'h7);

        // Reset mid-debounce, fresh debounce, then scan_en dropped while pressed
        do_reset();
        keys = 16'h0008;
        base = en_cnt;
        clks(8);
        chk("abort_pre_held", 32'(key_held), 32'h0);
        do_reset();
        chk("abort_row", 32'(row_out), 32'hE);
        chk("abort_held", 32'(key_held), 32'h0);
        chk("abort_data", 32'(keypad_data), 32'h0);
        chk("abort_count", 32'(en_cnt - base), 32'h0);
        clks(11); chk("fresh_pre_en", 32'(keypad_enable), 32'h0);
        clks(1);
        chk("fresh_en", 32'(keypad_enable), 32'h1);
        chk("fresh_data", 32'(keypad_data), 32'h3);
        clks(4);  chk("fresh_held", 32'(key_held), 32'h1);
        scan_en = 1'b0;
        clks(1);
        chk("dis_held", 32'(key_held), 32'h0);
        chk("dis_row", 32'(row_out), 32'hE);
        clks(8);
        chk("dis_row_frozen", 32'(row_out), 32'hE);
        chk("dis_held_low", 32'(key_held), 32'h0);
        chk("dis_en", 32'(keypad_enable), 32'h0);
        chk("dis_count", 32'(en_cnt - base), 32'h1);
        chk("dis_data_kept", 32'(keypad_data), 32'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
